seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed driver for a bank of `DIGITS` common-anode seven-segment displays. It sits between the numeric datapath and the pins: it latches a packed multi-nibble value and steps through the digits one at a time. Each digit's nibble goes through the shared combinational `seven_seg_decoder`. The scanner drives the segment lines and a one-hot digit select, with a blanking gap between digits to suppress ghosting.

## Interface

Reset is asynchronous and active-low; there is one clock (`clk`).

Parameters:
- `DIGITS`, default 4: number of display digits (2..8).
- `PRESCALE`, default 50000: SHOW cycles per digit slot (≥2).
- `BLANK_CYCLES`, default 1000: BLANK cycles before each SHOW (≥1).

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: scanning enabled. Low forces IDLE.
- `value`, in, 4*DIGITS: packed nibbles; digit 0 is `value[3:0]`.
- `load`, in, 1: one-cycle strobe that samples `value` into the pending register.
- `digit_sel`, out, DIGITS: one-hot active-high digit enable; all-zero outside SHOW.
- `segments`, out, 7: decoder output in SHOW, `SEG_OFF` otherwise.
- `frame_tick`, out, 1: one-cycle pulse at the start of each frame.

## Operation

- Registers:
  - `pending` (4*DIGITS) and `pending_valid`.
  - `shown` (4*DIGITS): the frame being displayed.
  - `idx` (0..DIGITS-1).
  - `cnt`: slot counter.
  - `state`: IDLE, BLANK or SHOW.
- FSM transitions:
  - IDLE → BLANK when `enable`=1. This entry sets `idx`=0 and starts a frame.
  - BLANK → SHOW when `cnt`=BLANK_CYCLES-1.
  - SHOW → BLANK when `cnt`=PRESCALE-1. On this transition `idx` increments; it wraps from DIGITS-1 to 0, and the wrap starts a new frame.
  - Any state → IDLE on the edge after `enable`=0. `idx` is cleared; `shown` and `pending` are retained.
  - `cnt` clears on every state change.
- Frame start:
  - Occurs on entry to BLANK with `idx`=0.
  - `frame_tick`=1 for exactly that cycle.
  - If `pending_valid`, then `shown` ← `pending` and `pending_valid` ← 0.
  - A frame therefore never mixes two values.
- Load:
  - `load`=1 sets `pending` ← `value` and `pending_valid` ← 1, in any state.
  - If `load` coincides with a frame-start edge, `shown` takes the new `value` directly (bypass) and `pending_valid` stays 0.
  - Back-to-back loads: the last one before a frame start wins.
- Output gating:
  - The decoder input is `shown[4*idx +: 4]`.
  - `digit_sel[idx]`=1 only in SHOW.
  - `segments` is the decoder output in SHOW and `SEG_OFF` elsewhere.
  - During BLANK, the next digit's nibble is already selected, so segments settle before the select asserts.
- Reset (async, mid-operation included):
  - state=IDLE; `idx`, `cnt`, `pending`, `pending_valid`, `shown` = 0.
  - `digit_sel`=0, `segments`=`SEG_OFF`, `frame_tick`=0.

## Timing

- `digit_sel`, `segments` and `frame_tick` are registered; they change only on `clk` edges and never glitch.
- `enable` first sampled high at edge k:
  - BLANK and `frame_tick` at k.
  - `digit_sel`=1 for digit 0 from edge k+BLANK_CYCLES, held for PRESCALE cycles.
- Slot length = BLANK_CYCLES+PRESCALE cycles. Frame length = DIGITS × slot.
- Load latency to display: `load` at edge m is visible at the first frame start at or after edge m, then reaches digit i's SHOW i slots later.

## Configuration

- `SEVEN_SEG_LZB_EN` defined: leading-zero blanking.
  - In SHOW, any digit i>0 whose nibble and all higher nibbles of `shown` are zero outputs `segments`=`SEG_OFF`.
  - `digit_sel` still asserts for that digit.
  - Digit 0 is always decoded.
- `SEVEN_SEG_LZB_EN` undefined: every digit is decoded.

## Structure

- Package `seven_seg_pkg`:
  - `SEG_OFF` = 7'b1111111 (active-low segments).
  - `scan_state_t` enum {IDLE, BLANK, SHOW}.
- Sub-module: one instance of the existing `seven_seg_decoder`, fed by the `idx` mux. The output register sits in the scanner.

## Test plan

1. Reset-hold check:
   - Stimulus: hold `rst_n`=0 with `enable`=1.
   - Response: `digit_sel`=0, `segments`=7'b1111111, `frame_tick`=0 throughout.
2. Basic scan:
   - Stimulus: DIGITS=4, PRESCALE=4, BLANK_CYCLES=2. `load` `value`=16'h4321, then `enable`=1.
   - Response: `frame_tick` fires once every 24 cycles. `digit_sel` steps through 0001, 0010, 0100, 1000 (four cycles each, two dark cycles between). `segments` equals the decoder code for 1, 2, 3, 4 respectively.
3. Mid-frame load:
   - Stimulus: `load` 16'h9999 while digit 1 is in SHOW.
   - Response: digits 2 and 3 still show 3 and 4. The next frame shows 9 on all digits.
4. Bypass load:
   - Stimulus: `load` 16'h0005 on the frame-start edge.
   - Response: digit 0 shows 5 in that same frame.
5. Disable and reset mid-operation:
   - Stimulus: drop `enable` during digit 2 SHOW, then re-enable.
   - Response: `digit_sel`=0 next edge; the scan restarts at digit 0 with `frame_tick`.
   - Stimulus: assert `rst_n`=0 asynchronously.
   - Response: outputs go to their reset values immediately.
6. Leading-zero blanking with `SEVEN_SEG_LZB_EN`:
   - Stimulus: `value`=16'h0070.
   - Response: digits 3 and 2 show `SEG_OFF` with `digit_sel` asserted. Digit 1 shows 7, digit 0 shows 0.
   - Without the macro: digits 3 and 2 show the code for 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display path.
// Segments are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam int         NIB_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-low seven-segment code, purely combinational.
// Zero latency; no flow control.
module seven_seg_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode display scanner; define SEVEN_SEG_LZB_EN for leading-zero blanking.
// Outputs registered from next-state decode; no backpressure, load is a one-cycle strobe.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NIB_W*DIGITS-1:0] value,
  input  logic                    load,
  output logic [DIGITS-1:0]       digit_sel,
  output logic [6:0]              segments,
  output logic                    frame_tick
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  scan_state_t               state, state_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [NIB_W*DIGITS-1:0]   pending, shown;
  logic                      pending_valid;
  logic                      frame_start;
  logic                      lz_blank;
  logic [3:0]                cur_nibble;
  logic [6:0]                dec_seg;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) state_nxt = SHOW;
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nxt = BLANK;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      endcase
    end

    if (state_nxt != state || state_nxt == IDLE) cnt_nxt = '0;
    else                                         cnt_nxt = cnt + 1'b1;

    // Every entry into BLANK at digit 0 begins a frame, whether from IDLE or the wrap.
    frame_start = (state_nxt == BLANK) && (state != BLANK) && (idx_nxt == '0);
  end

  // idx and shown never change on the BLANK->SHOW edge, so the decoder output
  // sampled here is already the one for the digit about to be lit.
  assign cur_nibble = shown[{idx, 2'b00} +: NIB_W];

  seven_seg_decoder u_decoder (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

`ifdef SEVEN_SEG_LZB_EN
  assign lz_blank = (idx != '0) && ((shown >> {idx, 2'b00}) == '0);
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      shown         <= '0;
      digit_sel     <= '0;
      segments      <= SEG_OFF;
      frame_tick    <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;

      if (load) pending <= value;

      // A load on the frame-start edge bypasses pending so it is not lost for a frame.
      if (frame_start) begin
        if (load)               shown <= value;
        else if (pending_valid) shown <= pending;
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_valid <= 1'b1;
      end

      frame_tick <= frame_start;
      digit_sel  <= (state_nxt == SHOW) ? (DIGITS'(1) << idx_nxt) : '0;
      segments   <= (state_nxt == SHOW && !lz_blank) ? dec_seg : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: frame-position model plus directed literal checks and random loads.
module tb_seven_seg_scanner;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int BLANK    = 2;
  localparam int SLOT     = BLANK + PRESCALE;
  localparam int FRAME    = DIGITS * SLOT;
  localparam logic [6:0] OFF = 7'b1111111;
`ifdef SEVEN_SEG_LZB_EN
  localparam bit         LZB     = 1'b1;
  localparam logic [6:0] ZERO_HI = OFF;
`else
  localparam bit         LZB     = 1'b0;
  localparam logic [6:0] ZERO_HI = 7'b1000000;
`endif

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] value;
  logic        load;
  logic [3:0]  digit_sel;
  logic [6:0]  segments;
  logic        frame_tick;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seven_seg_scanner #(
    .DIGITS       (DIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .value      (value),
    .load       (load),
    .digit_sel  (digit_sel),
    .segments   (segments),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: position within the frame since scanning began, plus the frame value.
  logic [15:0] m_shown, m_pend;
  logic        m_pv, m_run;
  int          m_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_shown = '0; m_pend = '0; m_pv = 1'b0; m_run = 1'b0; m_p = 0;
    end else begin
      if (!enable)     m_run = 1'b0;
      else if (!m_run) begin m_run = 1'b1; m_p = 0; end
      else             m_p = (m_p + 1) % FRAME;
      if (m_run && m_p == 0) begin
        if (load)      m_shown = value;
        else if (m_pv) m_shown = m_pend;
        m_pv = 1'b0;
      end else if (load) begin
        m_pv = 1'b1;
      end
      if (load) m_pend = value;
    end
  end

  function automatic logic [6:0] model_seg(input int d, input logic [15:0] v);
    logic [15:0] hi;
    hi = v >> (4 * d);
    if (LZB && d > 0 && hi == 16'h0) return OFF;
    return seg_tab[hi[3:0]];
  endfunction

  always @(negedge clk) begin
    int   d;
    logic show;
    d    = m_p / SLOT;
    show = m_run && ((m_p % SLOT) >= BLANK);
    check("model tick", 32'(frame_tick), 32'(m_run && m_p == 0));
    check("model sel", 32'(digit_sel), show ? 32'(1 << d) : 32'h0);
    check("model seg", 32'(segments), show ? 32'(model_seg(d, m_shown)) : 32'(OFF));
  end

  task automatic wait_sel(input logic [3:0] sel, input logic [6:0] seg, input string name);
    int n = 0;
    while (digit_sel !== sel && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, " sel"}, 32'(digit_sel), 32'(sel));
    check({name, " seg"}, 32'(segments), 32'(seg));
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n;
    rst_n  = 1'b0;
    enable = 1'b1;
    load   = 1'b0;
    value  = '0;

    repeat (6) @(negedge clk);
    check("reset sel", 32'(digit_sel), 32'h0);
    check("reset seg", 32'(segments), 32'(OFF));
    check("reset tick", 32'(frame_tick), 32'h0);

    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic scan.
    pulse_load(16'h4321);
    enable = 1'b1;
    @(negedge clk);
    check("enable tick", 32'(frame_tick), 32'h1);
    t0 = cyc;
    wait_sel(4'b0001, 7'b1111001, "scan d0");
    wait_sel(4'b0010, 7'b0100100, "scan d1");
    wait_sel(4'b0100, 7'b0110000, "scan d2");
    wait_sel(4'b1000, 7'b0011001, "scan d3");
    n = 0;
    while (frame_tick !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("frame period", 32'(cyc - t0), 32'd24);

    // Mid-frame load does not disturb the current frame.
    wait_sel(4'b0010, 7'b0100100, "mid d1");
    pulse_load(16'h9999);
    wait_sel(4'b0100, 7'b0110000, "mid d2");
    wait_sel(4'b1000, 7'b0011001, "mid d3");
    wait_sel(4'b0001, 7'b0010000, "mid next d0");

    // Load on the frame-start edge takes effect in that frame.
    wait_sel(4'b1000, 7'b0010000, "bypass pre d3");
    repeat (3) @(negedge clk);
    pulse_load(16'h0005);
    check("bypass tick", 32'(frame_tick), 32'h1);
    wait_sel(4'b0001, 7'b0010010, "bypass d0");
    wait_sel(4'b0010, ZERO_HI, "bypass d1");

    // Disable during digit 2, then resume.
    wait_sel(4'b0100, ZERO_HI, "dis d2");
    enable = 1'b0;
    @(negedge clk);
    check("dis sel", 32'(digit_sel), 32'h0);
    check("dis seg", 32'(segments), 32'(OFF));
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("reen tick", 32'(frame_tick), 32'h1);
    wait_sel(4'b0001, 7'b0010010, "reen d0");

    // Asynchronous reset mid-SHOW.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst sel", 32'(digit_sel), 32'h0);
    check("arst seg", 32'(segments), 32'(OFF));
    check("arst tick", 32'(frame_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Leading zeros.
    enable = 1'b0;
    @(negedge clk);
    pulse_load(16'h0070);
    enable = 1'b1;
    wait_sel(4'b0001, 7'b1000000, "lzb d0");
    wait_sel(4'b0010, 7'b1111000, "lzb d1");
    wait_sel(4'b0100, ZERO_HI, "lzb d2");
    wait_sel(4'b1000, ZERO_HI, "lzb d3");

    // Random loads and enable toggles against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 9) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) value[15:8] = 8'h00;
      if (enable && $urandom_range(0, 299) == 0)  enable = 1'b0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
    end
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
